mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu_arith.sv | 55 +++++
 rtl/mult_div_unit.sv | 125 ++++++++++++
 tb/tb_mult_div_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings and default latencies.
package mdu_pkg;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned MD_OP_W         = 3;
    localparam int unsigned MD_DATA_W       = 32;

    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MFHI  = 3'd6,
        MD_MFLO  = 3'd7
    } md_op_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: 64-bit products and 32-bit quotient/remainder for the MD unit.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [MD_DATA_W-1:0] srcA,
    input  logic [MD_DATA_W-1:0] srcB,
    input  logic [MD_OP_W-1:0]   MDOp,
    output logic [MD_DATA_W-1:0] hi,
    output logic [MD_DATA_W-1:0] lo,
    output logic                 divByZero
);

    logic [2*MD_DATA_W-1:0] prod_s;
    logic [2*MD_DATA_W-1:0] prod_u;
    logic                   div_signed;
    logic                   b_zero;
    logic [MD_DATA_W-1:0]   a_mag;
    logic [MD_DATA_W-1:0]   b_mag;
    logic [MD_DATA_W-1:0]   divisor;
    logic [MD_DATA_W-1:0]   q_mag;
    logic [MD_DATA_W-1:0]   r_mag;
    logic [MD_DATA_W-1:0]   quot;
    logic [MD_DATA_W-1:0]   rem;

    assign prod_s = {{MD_DATA_W{srcA[MD_DATA_W-1]}}, srcA} * {{MD_DATA_W{srcB[MD_DATA_W-1]}}, srcB};
    assign prod_u = {{MD_DATA_W{1'b0}}, srcA} * {{MD_DATA_W{1'b0}}, srcB};

    // Signed division runs on magnitudes; 0x80000000 maps to itself, which is the correct unsigned magnitude.
    assign div_signed = (MDOp == MD_DIV);
    assign b_zero     = (srcB == '0);
    assign a_mag      = (div_signed && srcA[MD_DATA_W-1]) ? (~srcA + 32'd1) : srcA;
    assign b_mag      = (div_signed && srcB[MD_DATA_W-1]) ? (~srcB + 32'd1) : srcB;
    assign divisor    = b_zero ? 32'd1 : b_mag;
    assign q_mag      = a_mag / divisor;
    assign r_mag      = a_mag % divisor;
    assign quot       = (div_signed && (srcA[MD_DATA_W-1] ^ srcB[MD_DATA_W-1])) ? (~q_mag + 32'd1) : q_mag;
    assign rem        = (div_signed && srcA[MD_DATA_W-1]) ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        hi        = '0;
        lo        = '0;
        divByZero = 1'b0;
        case (MDOp)
            MD_MULT:          {hi, lo} = prod_s;
            MD_MULTU:         {hi, lo} = prod_u;
            MD_DIV, MD_DIVU: begin
                hi        = rem;
                lo        = quot;
                divByZero = b_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO, busy handshake and deferred commit.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MD_OP_W-1:0]   MDOp,
    input  logic [MD_DATA_W-1:0] srcA,
    input  logic [MD_DATA_W-1:0] srcB,
    output logic                 busy,
    output logic [MD_DATA_W-1:0] HI,
    output logic [MD_DATA_W-1:0] LO,
    output logic [MD_DATA_W-1:0] MDResult
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic [MD_DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [MD_DATA_W-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic                   pend_we_q, pend_we_d;
    logic [MD_DATA_W-1:0]   ar_hi, ar_lo;
    logic                   ar_dbz;

    mdu_arith u_arith (
        .srcA      (srcA),
        .srcB      (srcB),
        .MDOp      (MDOp),
        .hi        (ar_hi),
        .lo        (ar_lo),
        .divByZero (ar_dbz)
    );

    // Next-state: launch captures the result immediately; HI/LO only change on the final busy edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (MDOp)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            pend_hi_d = ar_hi;
                            pend_lo_d = ar_lo;
                            pend_we_d = ~ar_dbz;
                            cnt_d     = ((MDOp == MD_MULT) || (MDOp == MD_MULTU)) ?
                                        CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                            busy_d    = 1'b1;
                            state_d   = BUSY;
                        end
                        MD_MTHI: hi_d = srcA;
                        MD_MTLO: lo_d = srcA;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

    // Move-from read port sees only committed HI/LO.
    always_comb begin
        MDResult = '0;
        case (MDOp)
            MD_MFHI: MDResult = hi_q;
            MD_MFLO: MDResult = lo_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized ops against a reference model.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  MDOp;
    logic [31:0] srcA, srcB;
    logic        busy;
    logic [31:0] HI, LO, MDResult;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi, m_lo;

    mult_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .MDOp     (MDOp),
        .srcA     (srcA),
        .srcB     (srcB),
        .busy     (busy),
        .HI       (HI),
        .LO       (LO),
        .MDResult (MDResult)
    );

    always #5 clk = ~clk;

    // Reference: architectural HI/LO after one op, using wide integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi, input logic [31:0] lo);
        longint          x, y, q, r;
        longint unsigned ux, uy, up;
        case (op)
            MD_MULT: begin
                x = longint'($signed(a));
                y = longint'($signed(b));
                return 64'(x * y);
            end
            MD_MULTU: begin
                ux = {32'd0, a};
                uy = {32'd0, b};
                up = ux * uy;
                return up;
            end
            MD_DIV: begin
                if (b == 32'd0) return {hi, lo};
                x = longint'($signed(a));
                y = longint'($signed(b));
                q = x / y;
                r = x % y;
                return {r[31:0], q[31:0]};
            end
            MD_DIVU: begin
                if (b == 32'd0) return {hi, lo};
                return {a % b, a / b};
            end
            MD_MTHI: return {a, lo};
            MD_MTLO: return {hi, a};
            default: return {hi, lo};
        endcase
    endfunction

    function automatic int exp_cycles(input logic [2:0] op);
        if (op == MD_MULT || op == MD_MULTU) return 5;
        if (op == MD_DIV || op == MD_DIVU) return 10;
        return 0;
    endfunction

    // Drive one op for one edge, then count edges until busy falls (bounded).
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int ncyc);
        start = 1'b1; MDOp = op; srcA = a; srcB = b;
        @(posedge clk); #1;
        start = 1'b0; MDOp = MD_MFHI;
        ncyc = 0;
        while (busy === 1'b1 && ncyc < 100) begin
            @(posedge clk); #1;
            ncyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; MDOp = MD_MFHI; srcA = '0; srcB = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", HI); end
        checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", LO); end
        @(negedge clk);
        reset = 1'b1; start = 1'b1; MDOp = MD_MTHI; srcA = 32'h0000_1111;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (HI !== 32'h0000_1111) begin errors++; $display("FAIL first_start_after_reset got=%h exp=00001111", HI); end
        m_hi = 32'h0000_1111; m_lo = 32'h0;
    endtask

    task automatic test_mult;
        int n;
        do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, n);
        checks++; if (n != 5) begin errors++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
        checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got=%h exp=fffffffa", LO); end
        m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFA;
    endtask

    task automatic test_div;
        int n;
        do_op(MD_DIVU, 32'd100, 32'd7, n);
        checks++; if (n != 10) begin errors++; $display("FAIL divu_busy_cycles got=%0d exp=10", n); end
        checks++; if (LO !== 32'd14 || HI !== 32'd2) begin errors++; $display("FAIL divu_result got=%h:%h exp=00000002:0000000e", HI, LO); end
        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, n);
        checks++; if (LO !== 32'hFFFF_FFFD || HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg got=%h:%h exp=ffffffff:fffffffd", HI, LO); end
        do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        checks++; if (LO !== 32'h8000_0000 || HI !== 32'h0) begin errors++; $display("FAIL div_overflow got=%h:%h exp=00000000:80000000", HI, LO); end
        m_hi = 32'h0; m_lo = 32'h8000_0000;
    endtask

    task automatic test_div_zero;
        int n;
        do_op(MD_MTHI, 32'h1234, 32'd0, n);
        checks++; if (n != 0) begin errors++; $display("FAIL mthi_no_busy got=%0d exp=0", n); end
        do_op(MD_MTLO, 32'h5678, 32'd0, n);
        do_op(MD_DIV, 32'd77, 32'd0, n);
        checks++; if (n != 10) begin errors++; $display("FAIL divzero_busy_cycles got=%0d exp=10", n); end
        checks++; if (HI !== 32'h1234 || LO !== 32'h5678) begin errors++; $display("FAIL divzero_keep got=%h:%h exp=00001234:00005678", HI, LO); end
        m_hi = 32'h1234; m_lo = 32'h5678;
    endtask

    task automatic test_busy_ignore;
        int n;
        start = 1'b1; MDOp = MD_MULTU; srcA = 32'hFFFF_FFFF; srcB = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            start = (n == 1); MDOp = MD_MTLO; srcA = 32'd5;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL busy_ignore_cycles got=%0d exp=5", n); end
        checks++; if (HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin errors++; $display("FAIL busy_ignore_result got=%h:%h exp=fffffffe:00000001", HI, LO); end
        m_hi = 32'hFFFF_FFFE; m_lo = 32'h1;
    endtask

    // A launch or move presented in the commit cycle must be dropped.
    task automatic test_commit_cycle;
        int n;
        logic [2:0] late_op;
        for (int k = 0; k < 2; k++) begin
            late_op = (k == 0) ? 3'(MD_MULTU) : 3'(MD_MTHI);
            start = 1'b1; MDOp = MD_MULT; srcA = 32'd7; srcB = 32'd6;
            @(posedge clk); #1;
            start = 1'b0;
            n = 0;
            while (busy === 1'b1 && n < 100) begin
                start = (n == 4); MDOp = late_op; srcA = 32'hDEAD; srcB = 32'd9;
                @(posedge clk); #1;
                start = 1'b0;
                n++;
            end
            @(posedge clk); #1;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL commit_cycle_busy k=%0d got=%0b exp=0", k, busy); end
            checks++; if (HI !== 32'h0 || LO !== 32'd42) begin errors++; $display("FAIL commit_cycle_regs k=%0d got=%h:%h exp=00000000:0000002a", k, HI, LO); end
        end
        m_hi = 32'h0; m_lo = 32'd42;
    endtask

    task automatic test_reset_mid;
        int n;
        do_op(MD_MTHI, 32'h55, 32'd0, n);
        do_op(MD_MTLO, 32'h66, 32'd0, n);
        start = 1'b1; MDOp = MD_DIV; srcA = 32'd100; srcB = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin errors++; $display("FAIL reset_mid_abort got busy=%0b %h:%h exp busy=0 0:0", busy, HI, LO); end
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin errors++; $display("FAIL reset_mid_no_commit got busy=%0b %h:%h exp busy=0 0:0", busy, HI, LO); end
        m_hi = 32'h0; m_lo = 32'h0;
    endtask

    task automatic test_mthi_mfhi;
        logic saw_busy;
        saw_busy = 1'b0;
        start = 1'b1; MDOp = MD_MTHI; srcA = 32'hAA;
        @(posedge clk); #1;
        saw_busy = saw_busy | busy;
        start = 1'b1; MDOp = MD_MFHI;
        #1;
        checks++; if (MDResult !== 32'hAA) begin errors++; $display("FAIL mfhi_result got=%h exp=000000aa", MDResult); end
        @(posedge clk); #1;
        saw_busy = saw_busy | busy;
        start = 1'b0;
        checks++; if (saw_busy !== 1'b0 || HI !== 32'hAA) begin errors++; $display("FAIL mthi_mfhi_state busy=%0b hi=%h exp busy=0 hi=000000aa", saw_busy, HI); end
        m_hi = 32'hAA;
        // During a multiply, MFLO must still return the old LO.
        start = 1'b1; MDOp = MD_MULTU; srcA = 32'd3; srcB = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; MDOp = MD_MFLO;
        #1;
        checks++; if (MDResult !== m_lo) begin errors++; $display("FAIL mflo_no_bypass got=%h exp=%h", MDResult, m_lo); end
        MDOp = MD_MULT;
        #1;
        checks++; if (MDResult !== 32'h0) begin errors++; $display("FAIL mdresult_other_op got=%h exp=0", MDResult); end
        for (int i = 0; i < 20 && busy === 1'b1; i++) begin @(posedge clk); #1; end
        m_hi = 32'h0; m_lo = 32'd9;
    endtask

    function automatic logic [31:0] pick_operand(input bit allow_zero);
        case ($urandom_range(0, 7))
            0: return allow_zero ? 32'h0 : 32'h1;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random;
        int n, en;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [63:0] nxt;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick_operand(1'b1);
            b  = pick_operand(1'b1);
            en  = exp_cycles(op);
            nxt = model(op, a, b, m_hi, m_lo);
            do_op(op, a, b, n);
            m_hi = nxt[63:32]; m_lo = nxt[31:0];
            checks++; if (n != en) begin errors++; $display("FAIL rand_cycles i=%0d op=%0d got=%0d exp=%0d", i, op, n, en); end
            checks++; if (HI !== m_hi || LO !== m_lo) begin errors++; $display("FAIL rand_regs i=%0d op=%0d a=%h b=%h got=%h:%h exp=%h:%h", i, op, a, b, HI, LO, m_hi, m_lo); end
            MDOp = MD_MFLO;
            #1;
            checks++; if (MDResult !== m_lo) begin errors++; $display("FAIL rand_mflo i=%0d got=%h exp=%h", i, MDResult, m_lo); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_commit_cycle();
        test_reset_mid();
        test_mthi_mfhi();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
